// File: rtl/nonce_result_collector.sv
`default_nettype none
// ============================================================================
// nonce_result_collector - scans hash macros round-robin, reads each 4-byte
// nonce over the shared read bus and queues {nonce, macro} in a result FIFO.
// Revision 1.0
// ============================================================================
module nonce_result_collector #(
    parameter int         NUM_MACROS       = 4,
    parameter int         FIFO_DEPTH       = 4,
    parameter logic [5:0] RESULT_BASE_ADDR = 6'h3C,
    parameter int         RD_WAIT          = 2,
    parameter int         HOLDOFF          = 4,
    localparam int        IDX_W            = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1,
    localparam int        CNT_W            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  M1_CLK,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    input  logic [7:0]            DATA_FROM_HASH,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]            HASH_ADDR,
    output logic                  busy,
    input  logic                  pop,
    output logic [31:0]           head_nonce,
    output logic [IDX_W-1:0]      head_macro,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_empty,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic                  irq
);

    localparam int                PTR_W     = CNT_W - 1;
    localparam int                HO_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [2:0]        WAIT_INIT = 3'(RD_WAIT - 1);
    localparam logic [HO_W-1:0]   HO_INIT   = HO_W'(HOLDOFF - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_MACROS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        PUSH = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [NUM_MACROS-1:0]   sel, sel_nx;
    logic [5:0]              addr, addr_nx;
    logic [1:0]              byte_k, byte_k_nx;
    logic [2:0]              wait_cnt, wait_cnt_nx;
    logic [IDX_W-1:0]        cur_idx, cur_idx_nx;
    logic [IDX_W-1:0]        rr, rr_nx;
    logic [31:0]             nonce_acc, nonce_acc_nx;
    logic                    busy_nx;
    logic                    push_req;

    logic [NUM_MACROS-1:0]   mask;
    logic [NUM_MACROS-1:0]   eligible;
    logic                    found;
    logic [IDX_W-1:0]        pick;

    logic [31:0]             nonce_mem [FIFO_DEPTH];
    logic [IDX_W-1:0]        macro_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic                    full, do_push, do_pop, drop;

    assign MACRO_RD_SELECT = sel;
    assign HASH_ADDR       = addr;

    // First eligible macro at or after the round-robin pointer, wrapping.
    always_comb begin : p_arb
        logic [IDX_W:0] j;
        found    = 1'b0;
        pick     = '0;
        j        = '0;
        eligible = DATA_AVAILABLE & ~mask;
        for (int i = 0; i < NUM_MACROS; i++) begin
            j = {1'b0, rr} + (IDX_W+1)'(i);
            if (j >= (IDX_W+1)'(NUM_MACROS)) begin
                j = j - (IDX_W+1)'(NUM_MACROS);
            end
            if (!found && eligible[j[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = j[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge M1_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            sel       <= '0;
            addr      <= '0;
            byte_k    <= '0;
            wait_cnt  <= '0;
            cur_idx   <= '0;
            rr        <= '0;
            nonce_acc <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            addr      <= addr_nx;
            byte_k    <= byte_k_nx;
            wait_cnt  <= wait_cnt_nx;
            cur_idx   <= cur_idx_nx;
            rr        <= rr_nx;
            nonce_acc <= nonce_acc_nx;
            busy      <= busy_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        addr_nx      = addr;
        byte_k_nx    = byte_k;
        wait_cnt_nx  = wait_cnt;
        cur_idx_nx   = cur_idx;
        rr_nx        = rr;
        nonce_acc_nx = nonce_acc;
        busy_nx      = busy;
        push_req     = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE && found) begin
                    state_nx     = READ;
                    sel_nx       = '0;
                    sel_nx[pick] = 1'b1;
                    addr_nx      = RESULT_BASE_ADDR;
                    byte_k_nx    = 2'd0;
                    wait_cnt_nx  = WAIT_INIT;
                    cur_idx_nx   = pick;
                    busy_nx      = 1'b1;
                end
            end
            READ: begin
                if (wait_cnt == 3'd0) begin
                    nonce_acc_nx[{byte_k, 3'b000} +: 8] = DATA_FROM_HASH;
                    if (byte_k == 2'd3) begin
                        state_nx = PUSH;
                        sel_nx   = '0;
                        addr_nx  = '0;
                    end else begin
                        addr_nx     = addr + 6'd1;
                        byte_k_nx   = byte_k + 2'd1;
                        wait_cnt_nx = WAIT_INIT;
                    end
                end else begin
                    wait_cnt_nx = wait_cnt - 3'd1;
                end
            end
            PUSH: begin
                push_req = 1'b1;
                rr_nx    = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
                state_nx = HOLD;
            end
            HOLD: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Per-macro holdoff masks ride out the macro's late DATA_AVAILABLE deassert.
    for (genvar g = 0; g < NUM_MACROS; g++) begin : g_holdoff
        logic            m;
        logic [HO_W-1:0] cnt;
        always_ff @(posedge M1_CLK or negedge RST_N) begin
            if (!RST_N) begin
                m   <= 1'b0;
                cnt <= '0;
            end else if (push_req && (cur_idx == IDX_W'(g))) begin
                m   <= 1'b1;
                cnt <= HO_INIT;
            end else if (m) begin
                if (cnt == '0) begin
                    m <= 1'b0;
                end else begin
                    cnt <= cnt - HO_W'(1);
                end
            end
        end
        assign mask[g] = m;
    end

    assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign irq        = !fifo_empty;
    assign do_pop     = pop && !fifo_empty;
    assign do_push    = push_req && (!full || pop);
    assign drop       = push_req && !do_push;
    assign head_nonce = nonce_mem[rd_ptr];
    assign head_macro = macro_mem[rd_ptr];

    always_ff @(posedge M1_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                nonce_mem[i] <= '0;
                macro_mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                nonce_mem[wr_ptr] <= nonce_acc;
                macro_mem[wr_ptr] <= cur_idx;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A drop coinciding with clear_overflow keeps the flag set.
    always_ff @(posedge M1_CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_collector.sv
`default_nettype none
// ============================================================================
// tb_nonce_result_collector - directed self-checking bench with a simple
// per-macro read-port model.
// Revision 1.0
// ============================================================================
module tb_nonce_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  data_avail;
    logic [7:0]  hash_data;
    logic [3:0]  rd_sel;
    logic [5:0]  hash_addr;
    logic        busy;
    logic        pop;
    logic [31:0] head_nonce;
    logic [1:0]  head_macro;
    logic [2:0]  fifo_count;
    logic        fifo_empty;
    logic        overflow;
    logic        clear_ovf;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] nonce_tbl [4] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'h44332211, 32'hD3D2D1D0};

    always #5 clk = ~clk;

    nonce_result_collector dut (
        .M1_CLK          (clk),
        .RST_N           (rst_n),
        .ENABLE          (enable),
        .DATA_AVAILABLE  (data_avail),
        .DATA_FROM_HASH  (hash_data),
        .MACRO_RD_SELECT (rd_sel),
        .HASH_ADDR       (hash_addr),
        .busy            (busy),
        .pop             (pop),
        .head_nonce      (head_nonce),
        .head_macro      (head_macro),
        .fifo_count      (fifo_count),
        .fifo_empty      (fifo_empty),
        .overflow        (overflow),
        .clear_overflow  (clear_ovf),
        .irq             (irq)
    );

    // Macro read ports: nonce bytes live at 3C..3F, LSB first.
    always_comb begin
        hash_data = 8'h00;
        for (int m = 0; m < 4; m++) begin
            if (rd_sel[m] && (hash_addr[5:2] == 4'hF)) begin
                hash_data = nonce_tbl[m][{hash_addr[1:0], 3'b000} +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        data_avail = 4'b0000;
        pop        = 1'b0;
        clear_ovf  = 1'b0;

        // ---------------- reset state
        #12;
        chk("rst_sel",   32'(rd_sel), 32'h0);
        chk("rst_addr",  32'(hash_addr), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_irq",   32'(irq), 32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);
        chk("rst_head",  head_nonce, 32'h0);
        chk("rst_hmac",  32'(head_macro), 32'h0);

        // ---------------- single result from macro 2
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        enable     = 1'b1;
        data_avail = 4'b0100;
        tick(1);
        chk("s_sel",   32'(rd_sel), 32'h4);
        chk("s_addr0", 32'(hash_addr), 32'h3C);
        chk("s_busy",  32'(busy), 32'h1);
        data_avail = 4'b0000;
        tick(1);
        chk("s_addr0b", 32'(hash_addr), 32'h3C);
        tick(1);
        chk("s_addr1", 32'(hash_addr), 32'h3D);
        tick(2);
        chk("s_addr2", 32'(hash_addr), 32'h3E);
        tick(2);
        chk("s_addr3", 32'(hash_addr), 32'h3F);
        chk("s_sel3",  32'(rd_sel), 32'h4);
        tick(2);
        chk("s_push_sel",  32'(rd_sel), 32'h0);
        chk("s_push_addr", 32'(hash_addr), 32'h0);
        chk("s_pre_count", 32'(fifo_count), 32'h0);
        tick(1);
        chk("s_count", 32'(fifo_count), 32'h1);
        chk("s_nonce", head_nonce, 32'h44332211);
        chk("s_hmac",  32'(head_macro), 32'h2);
        chk("s_irq",   32'(irq), 32'h1);
        tick(1);
        chk("s_idle_busy", 32'(busy), 32'h0);
        pop_one();
        chk("s_pop_empty", 32'(fifo_empty), 32'h1);
        chk("s_pop_irq",   32'(irq), 32'h0);

        // ---------------- reset during byte 2, then fresh read
        data_avail = 4'b0010;
        tick(1);
        tick(5);
        chk("r_mid_addr", 32'(hash_addr), 32'h3E);
        rst_n = 1'b0;
        #1;
        chk("r_sel",   32'(rd_sel), 32'h0);
        chk("r_addr",  32'(hash_addr), 32'h0);
        chk("r_busy",  32'(busy), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("r_new_sel",  32'(rd_sel), 32'h2);
        chk("r_new_addr", 32'(hash_addr), 32'h3C);
        data_avail = 4'b0000;
        tick(8);
        chk("r_no_partial", 32'(fifo_count), 32'h0);
        tick(1);
        chk("r_count", 32'(fifo_count), 32'h1);
        chk("r_nonce", head_nonce, 32'hB3B2B1B0);
        chk("r_hmac",  32'(head_macro), 32'h1);
        tick(1);
        pop_one();

        // ---------------- round-robin with rr=0, macros 0 and 3
        reset_pulse();
        data_avail = 4'b1001;
        tick(1);
        chk("rr_first", 32'(rd_sel), 32'h1);
        data_avail = 4'b1000;
        tick(10);
        tick(1);
        chk("rr_second", 32'(rd_sel), 32'h8);
        data_avail = 4'b0000;
        tick(9);
        chk("rr_count", 32'(fifo_count), 32'h2);
        chk("rr_h0",    32'(head_macro), 32'h0);
        chk("rr_n0",    head_nonce, 32'hA3A2A1A0);
        pop_one();
        chk("rr_h1", 32'(head_macro), 32'h3);
        chk("rr_n1", head_nonce, 32'hD3D2D1D0);
        pop_one();
        chk("rr_empty", 32'(fifo_empty), 32'h1);
        tick(4);
        data_avail = 4'b1010;
        tick(1);
        chk("rr_wrap", 32'(rd_sel), 32'h2);
        data_avail = 4'b0000;
        tick(10);
        pop_one();
        tick(4);

        // ---------------- overflow: five results, no pops (order 2,3,0,1,2)
        data_avail = 4'b1111;
        tick(45);
        data_avail = 4'b0000;
        tick(8);
        chk("o_pre_ovf",   32'(overflow), 32'h0);
        chk("o_pre_count", 32'(fifo_count), 32'h4);
        tick(1);
        chk("o_ovf",   32'(overflow), 32'h1);
        chk("o_count", 32'(fifo_count), 32'h4);
        chk("o_hmac",  32'(head_macro), 32'h2);
        chk("o_nonce", head_nonce, 32'h44332211);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("o_clear", 32'(overflow), 32'h0);

        // ---------------- full FIFO with pop in the PUSH cycle
        data_avail = 4'b1000;
        tick(1);
        data_avail = 4'b0000;
        tick(8);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        chk("f_count", 32'(fifo_count), 32'h4);
        chk("f_ovf",   32'(overflow), 32'h0);
        chk("f_h0",    32'(head_macro), 32'h3);
        pop_one();
        chk("f_h1", 32'(head_macro), 32'h0);
        pop_one();
        chk("f_h2", 32'(head_macro), 32'h1);
        pop_one();
        chk("f_h3",    32'(head_macro), 32'h3);
        chk("f_n3",    head_nonce, 32'hD3D2D1D0);
        pop_one();
        chk("f_empty", 32'(fifo_empty), 32'h1);
        tick(2);

        // ---------------- holdoff: short tail serviced once, long tail twice
        data_avail = 4'b0010;
        tick(1);
        chk("h_start", 32'(busy), 32'h1);
        tick(9);
        chk("h_count1", 32'(fifo_count), 32'h1);
        tick(3);
        data_avail = 4'b0000;
        chk("h_masked", 32'(busy), 32'h0);
        tick(5);
        chk("h_once_busy",  32'(busy), 32'h0);
        chk("h_once_count", 32'(fifo_count), 32'h1);
        pop_one();

        data_avail = 4'b0010;
        tick(1);
        tick(9);
        chk("h2_count", 32'(fifo_count), 32'h1);
        tick(4);
        chk("h2_still_masked", 32'(busy), 32'h0);
        tick(1);
        chk("h2_again_busy", 32'(busy), 32'h1);
        chk("h2_again_sel",  32'(rd_sel), 32'h2);
        data_avail = 4'b0000;
        tick(9);
        chk("h2_count2", 32'(fifo_count), 32'h2);
        chk("h2_hmac",   32'(head_macro), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nonce_result_collector.md
Name: nonce_result_collector

Overview:
- Downstream consumer of the hash macro read bus (DATA_AVAILABLE, MACRO_RD_SELECT, HASH_ADDR, DATA_FROM_HASH) on the M1 clock domain.
- Round-robin scans the macros for found nonces and reads each 4-byte solution through the shared 8-bit read port.
- Queues each result with its macro index in a small FIFO. The register bank pops the FIFO and raises the SPI interrupt from it.
- Replaces direct per-byte host polling of macros.

Parameters:
- NUM_MACROS, 4, number of hash macros; width of the select and available buses.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, minimum 2.
- RESULT_BASE_ADDR, 6'h3C, HASH_ADDR of nonce byte 0 (LSB); bytes 1..3 sit at base+1..base+3.
- RD_WAIT, 2, cycles HASH_ADDR/MACRO_RD_SELECT are held before DATA_FROM_HASH is sampled; range 1..7.
- HOLDOFF, 4, cycles a serviced macro stays masked after its read completes.

Ports:
- M1_CLK  in  1  hash/M1 clock.
- RST_N  in  1  reset: asynchronous assert, active-low.
- ENABLE  in  1  scanning enable from the register bank.
- DATA_AVAILABLE  in  NUM_MACROS  per-macro nonce-found flags.
- DATA_FROM_HASH  in  8  read data from the selected macro.
- MACRO_RD_SELECT  out  NUM_MACROS  one-hot read select; all-zero when idle.
- HASH_ADDR  out  6  read address.
- busy  out  1  read sequence in progress.
- pop  in  1  single-cycle pop strobe from the register bank.
- head_nonce  out  32  FIFO head nonce, {b3,b2,b1,b0}.
- head_macro  out  clog2(NUM_MACROS)  macro index of the head entry.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- fifo_empty  out  1  occupancy==0.
- overflow  out  1  sticky; a result was dropped.
- clear_overflow  in  1  clears overflow.
- irq  out  1  equals !fifo_empty.

Behaviour:
- Reset (RST_N low, async) clears the following; mid-sequence reset abandons the read with no partial push.
  - MACRO_RD_SELECT=0, HASH_ADDR=0, busy=0.
  - fifo_count=0, fifo_empty=1, irq=0, overflow=0.
  - head_nonce=0, head_macro=0.
  - rr pointer=0, holdoff masks=0, FSM=IDLE.
- FSM states IDLE, READ, PUSH, HOLD.
- IDLE:
  - Waits for ENABLE=1 and at least one bit of DATA_AVAILABLE & ~mask.
  - Picks the first such index at or after rr, wrapping.
  - Next edge: MACRO_RD_SELECT=onehot(idx), HASH_ADDR=RESULT_BASE_ADDR, byte k=0, wait counter=RD_WAIT-1, busy=1, go to READ.
- READ:
  - Decrements the wait counter each cycle.
  - When it reaches 0: samples DATA_FROM_HASH into byte k.
  - If k<3: HASH_ADDR+=1 (6-bit wrap allowed), k+=1, counter reloads RD_WAIT-1.
  - If k==3: go to PUSH.
  - Result: byte k is sampled RD_WAIT cycles after its address is first driven.
- PUSH (one cycle):
  - MACRO_RD_SELECT=0, HASH_ADDR=0.
  - Writes {nonce, idx} if the FIFO is not full, or if full with pop asserted the same cycle (simultaneous pop+push: count unchanged, entry accepted).
  - Otherwise drops the result and sets overflow.
  - Sets mask[idx], loads the holdoff counter, rr=idx+1 mod NUM_MACROS, go to HOLD.
- HOLD:
  - Returns to IDLE immediately; busy=0 on entering IDLE.
  - mask[idx] clears after HOLDOFF cycles, independently of the FSM. This covers the macro's delayed DATA_AVAILABLE deassert.
  - A second available macro may be serviced during holdoff.
- ENABLE deassert mid-sequence: the sequence completes, then the block idles.
- DATA_AVAILABLE dropping mid-read: ignored; the sequence completes.
- Total latency from the IDLE decision to the PUSH edge is 1+4*RD_WAIT cycles (9 at default).
- FIFO:
  - Registered storage; head_* reflect the read pointer (valid whenever !fifo_empty; stale data when empty).
  - pop while empty is ignored.
  - Pointers wrap mod FIFO_DEPTH.
  - Full when count==FIFO_DEPTH.
- overflow:
  - clear_overflow clears it.
  - A drop in the same cycle as clear_overflow leaves overflow=1 (set wins).

Test Plan:
- Single result: macro 2 raises DATA_AVAILABLE; bytes at 3C..3F are 11,22,33,44. Required response:
  - HASH_ADDR steps 3C→3F, each held 2 cycles.
  - MACRO_RD_SELECT=4'b0100.
  - After 9 cycles, head_nonce=32'h44332211, head_macro=2, irq=1, fifo_count=1.
  - pop returns fifo_empty=1, irq=0.
- Round-robin: macros 0 and 3 available together with rr=0 → macro 0 is serviced first, then macro 3. FIFO order is 0,3; rr=0 after the second push.
- Overflow: push 5 results with no pops at FIFO_DEPTH=4 → fifo_count=4 and overflow=1. The head is still the first result. clear_overflow → overflow=0.
- Full with simultaneous pop: FIFO full, pop asserted in the PUSH cycle → new entry accepted, count stays 4, overflow stays 0.
- Holdoff: macro 1 keeps DATA_AVAILABLE high for 3 cycles after the read → serviced exactly once. It is held high 10 cycles → serviced again after HOLDOFF.
- Reset mid-read: RST_N low during byte 2 → outputs clear immediately, no FIFO entry. After release with DATA_AVAILABLE still high, a full fresh read starts at 3C.
